// File: rtl/pending_write_sched_pkg.sv
// pending_write_sched_pkg: shared types for the store-commit scheduler.
// Holds the FSM encoding, the store entry layout and the a0 index.
package pending_write_sched_pkg;

  localparam int PWS_W = 64;
  localparam logic [4:0] A0_REG = 5'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CALL,
    ST_WAIT,
    ST_WB
  } state_t;

  typedef struct packed {
    logic [PWS_W-1:0] addr;
    logic [PWS_W-1:0] data;
    logic [3:0]       size;
  } entry_t;

  // Anything that is not a 1/2/4-byte one-hot is treated as a doubleword.
  function automatic logic [3:0] norm_size(input logic [3:0] s);
    logic [3:0] r;
    case (s)
      4'b0001,
      4'b0010,
      4'b0100: r = s;
      default: r = 4'b1000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pending_write_sched_fifo.sv
// pws_fifo: power-of-two circular store queue with occupancy count.
// Push when full and pop when empty are ignored.
module pws_fifo
  import pending_write_sched_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (do_push & ~do_pop)
        count <= count + (AW + 1)'(1);
      else if (do_pop & ~do_push)
        count <= count - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pending_write_sched.sv
// pending_write_sched: store write queue plus ecall drain/call/writeback FSM.
// Define PWS_BYPASS_EN to let a store hit an empty queue's output directly.
module pending_write_sched
  import pending_write_sched_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_wr_valid,
  input  logic [BUS_DATA_WIDTH-1:0] in_wr_addr,
  input  logic [BUS_DATA_WIDTH-1:0] in_wr_data,
  input  logic [3:0]                in_wr_size,
  input  logic                      in_stall,
  output logic                      out_stall,
  output logic                      out_mem_valid,
  output logic [BUS_DATA_WIDTH-1:0] out_mem_addr,
  output logic [BUS_DATA_WIDTH-1:0] out_mem_data,
  output logic [3:0]                out_mem_size,
  input  logic                      in_mem_ready,
  input  logic                      in_ecall_req,
  output logic                      out_flush,
  output logic                      out_ecall_go,
  input  logic                      in_ecall_done,
  input  logic [BUS_DATA_WIDTH-1:0] in_ecall_ret,
  output logic                      out_rf_we,
  output logic [4:0]                out_rf_dest,
  output logic [BUS_DATA_WIDTH-1:0] out_rf_data
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (BUS_DATA_WIDTH != PWS_W) begin : g_width_check
    $error("BUS_DATA_WIDTH must match the package entry width");
  end

  state_t                      state;
  logic [CW-1:0]               count;
  logic                        full;
  logic                        empty;
  logic                        idle;
  logic                        accept;
  logic                        push;
  logic                        pop;
  logic                        drained;
  logic                        go_q;
  logic                        rf_we_q;
  logic [BUS_DATA_WIDTH-1:0]   ret_q;
  entry_t                      in_ent;
  entry_t                      head;
  entry_t                      shown;

  assign idle   = state == ST_IDLE;
  assign accept = in_wr_valid & ~in_stall & ~full & idle;

  assign in_ent = '{
    addr: in_wr_addr,
    data: in_wr_data,
    size: norm_size(in_wr_size)
  };

`ifdef PWS_BYPASS_EN
  logic bypass;

  // An empty queue forwards the incoming store; it is only
  // written into the queue if memory cannot take it this cycle.
  assign bypass        = accept & empty;
  assign out_mem_valid = ~empty | bypass;
  assign shown         = empty ? in_ent : head;
  assign push          = accept & ~(bypass & in_mem_ready);
  assign pop           = ~empty & in_mem_ready;
`else
  assign out_mem_valid = ~empty;
  assign shown         = head;
  assign push          = accept;
  assign pop           = out_mem_valid & in_mem_ready;
`endif

  pws_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_ent),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign out_mem_addr = out_mem_valid ? shown.addr : '0;
  assign out_mem_data = out_mem_valid ? shown.data : '0;
  assign out_mem_size = out_mem_valid ? shown.size : '0;

  assign out_stall = (in_wr_valid & full) | ~idle;
  assign out_flush = idle & in_ecall_req & ~in_stall;

  // Queue is empty after this edge, including a last head retiring now.
  assign drained = (count == '0)
                 | ((count == CW'(1)) & pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      go_q    <= 1'b0;
      rf_we_q <= 1'b0;
      ret_q   <= '0;
    end else begin
      go_q    <= 1'b0;
      rf_we_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (in_ecall_req & ~in_stall)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drained) begin
            state <= ST_CALL;
            go_q  <= 1'b1;
          end
        end
        ST_CALL: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (in_ecall_done) begin
            state   <= ST_WB;
            ret_q   <= in_ecall_ret;
            rf_we_q <= 1'b1;
          end
        end
        ST_WB: begin
          state <= ST_IDLE;
          ret_q <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_ecall_go = go_q;
  assign out_rf_we    = rf_we_q;
  assign out_rf_dest  = rf_we_q ? A0_REG : 5'd0;
  assign out_rf_data  = ret_q;

endmodule

// File: tb/tb_pending_write_sched.sv
// tb_pending_write_sched: directed stimulus checked every cycle against
// a queue-based model, plus hand-computed literal expectations.
module tb_pending_write_sched;

  localparam int DEPTH = 4;
  localparam int W     = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_wr_valid;
  logic [W-1:0] in_wr_addr;
  logic [W-1:0] in_wr_data;
  logic [3:0]   in_wr_size;
  logic         in_stall;
  logic         out_stall;
  logic         out_mem_valid;
  logic [W-1:0] out_mem_addr;
  logic [W-1:0] out_mem_data;
  logic [3:0]   out_mem_size;
  logic         in_mem_ready;
  logic         in_ecall_req;
  logic         out_flush;
  logic         out_ecall_go;
  logic         in_ecall_done;
  logic [W-1:0] in_ecall_ret;
  logic         out_rf_we;
  logic [4:0]   out_rf_dest;
  logic [W-1:0] out_rf_data;

  pending_write_sched #(
    .DEPTH          (DEPTH),
    .BUS_DATA_WIDTH (W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_wr_valid   (in_wr_valid),
    .in_wr_addr    (in_wr_addr),
    .in_wr_data    (in_wr_data),
    .in_wr_size    (in_wr_size),
    .in_stall      (in_stall),
    .out_stall     (out_stall),
    .out_mem_valid (out_mem_valid),
    .out_mem_addr  (out_mem_addr),
    .out_mem_data  (out_mem_data),
    .out_mem_size  (out_mem_size),
    .in_mem_ready  (in_mem_ready),
    .in_ecall_req  (in_ecall_req),
    .out_flush     (out_flush),
    .out_ecall_go  (out_ecall_go),
    .in_ecall_done (in_ecall_done),
    .in_ecall_ret  (in_ecall_ret),
    .out_rf_we     (out_rf_we),
    .out_rf_dest   (out_rf_dest),
    .out_rf_data   (out_rf_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [3:0]  size;
  } st_t;

  // Model: pending stores in order, ecall phase, captured return.
  st_t         mq[$];
  int          phase;
  logic [63:0] mret;

  function automatic logic [3:0] nsize(input logic [3:0] s);
    return (s == 4'd1 || s == 4'd2 || s == 4'd4) ? s : 4'd8;
  endfunction

  always @(negedge clk) begin
    bit   e_full, e_acc, e_valid, e_pop;
    st_t  inc, e_head;
    int   n0;
    if (reset) begin
      mq.delete();
      phase = 0;
      mret  = '0;
    end else begin
      n0      = mq.size();
      e_full  = (n0 == DEPTH);
      e_acc   = in_wr_valid && !in_stall && !e_full && phase == 0;
      inc     = '{in_wr_addr, in_wr_data, nsize(in_wr_size)};
      e_valid = (n0 != 0);
      e_head  = '{64'd0, 64'd0, 4'd0};
      if (n0 != 0) e_head = mq[0];
`ifdef PWS_BYPASS_EN
      if (n0 == 0 && e_acc) begin
        e_valid = 1'b1;
        e_head  = inc;
      end
`endif
      chk("mem_valid", out_mem_valid, e_valid);
      chk("mem_addr", out_mem_addr, e_head.addr);
      chk("mem_data", out_mem_data, e_head.data);
      chk("mem_size", out_mem_size, e_head.size);
      chk("stall", out_stall, (in_wr_valid && e_full) || phase != 0);
      chk("flush", out_flush, phase == 0 && in_ecall_req && !in_stall);
      chk("ecall_go", out_ecall_go, phase == 2);
      chk("rf_we", out_rf_we, phase == 4);
      chk("rf_dest", out_rf_dest, phase == 4 ? 64'd10 : 64'd0);
      chk("rf_data", out_rf_data, phase == 4 ? mret : 64'd0);

      e_pop = e_valid && in_mem_ready;
      if (e_pop && n0 != 0) mq.delete(0);
`ifdef PWS_BYPASS_EN
      if (e_acc && !(n0 == 0 && in_mem_ready)) mq.push_back(inc);
`else
      if (e_acc) mq.push_back(inc);
`endif
      case (phase)
        0: if (in_ecall_req && !in_stall) phase = 1;
        1: if (mq.size() == 0) phase = 2;
        2: phase = 3;
        3: if (in_ecall_done) begin
             mret  = in_ecall_ret;
             phase = 4;
           end
        default: phase = 0;
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d,
                       input logic [3:0] s);
    in_wr_valid = 1'b1;
    in_wr_addr  = a;
    in_wr_data  = d;
    in_wr_size  = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] sz [5];
    sz = '{4'b0010, 4'b0100, 4'b0000, 4'b1111, 4'b1000};
    reset = 1'b1;
    in_wr_valid = 0; in_wr_addr = 0; in_wr_data = 0; in_wr_size = 0;
    in_stall = 0; in_mem_ready = 0; in_ecall_req = 0;
    in_ecall_done = 0; in_ecall_ret = 0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst_valid", out_mem_valid, 0);
    chk("rst_stall", out_stall, 0);
    chk("rst_rf_we", out_rf_we, 0);
    chk("rst_go", out_ecall_go, 0);

    // single store latency
    cyc();
    store(64'h1000, 64'hAB, 4'b0001);
    in_mem_ready = 1'b1;
    #1;
`ifdef PWS_BYPASS_EN
    chk("byp_valid0", out_mem_valid, 1);
    chk("byp_addr0", out_mem_addr, 64'h1000);
`else
    chk("lat_valid0", out_mem_valid, 0);
`endif
    cyc();
    in_wr_valid = 0;
    #1;
`ifdef PWS_BYPASS_EN
    chk("byp_valid1", out_mem_valid, 0);
`else
    chk("lat_valid1", out_mem_valid, 1);
    chk("lat_addr1", out_mem_addr, 64'h1000);
    chk("lat_size1", out_mem_size, 4'b0001);
`endif
    cyc();

    // fill past DEPTH with memory stalled
    in_mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      store(64'h2000 + 64'(i * 8), 64'h100 + 64'(i), 4'b1000);
      cyc();
    end
    store(64'h2020, 64'h104, 4'b1000);
    #1;
    chk("full_stall", out_stall, 1);
    cyc();
    in_mem_ready = 1;
    #1;
    chk("full_stall_ready", out_stall, 1);
    cyc();
    chk("after_pop_stall", out_stall, 0);
    chk("after_pop_head", out_mem_addr, 64'h2008);
    cyc();
    in_wr_valid = 0;
    repeat (6) cyc();

    // size normalisation
    in_mem_ready = 0;
    store(64'h3000, 64'h33, 4'b0011);
    cyc();
    in_wr_valid = 0;
    #1;
    chk("norm_0011", out_mem_size, 4'b1000);
    in_mem_ready = 1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      store(64'h3100 + 64'(i), 64'h40 + 64'(i), sz[i]);
      cyc();
    end
    in_wr_valid = 0;
    repeat (2) cyc();

    // ecall done while idle must be ignored
    in_ecall_done = 1;
    in_ecall_ret  = 64'h55;
    cyc();
    in_ecall_done = 0;
    #1;
    chk("idle_done_ign", out_rf_we, 0);

    // ecall with two pending stores
    in_mem_ready = 0;
    store(64'h4000, 64'h1, 4'b0001);
    cyc();
    store(64'h4008, 64'h2, 4'b0010);
    cyc();
    in_wr_valid  = 0;
    in_ecall_req = 1;
    #1;
    chk("ec_flush", out_flush, 1);
    cyc();
    in_ecall_req = 0;
    #1;
    chk("ec_flush_off", out_flush, 0);
    chk("ec_drain_stall", out_stall, 1);
    cyc();
    chk("ec_hold_go", out_ecall_go, 0);
    in_mem_ready = 1;
    cyc();
    cyc();
    chk("ec_go", out_ecall_go, 1);
    cyc();
    chk("ec_go_once", out_ecall_go, 0);
    cyc();
    in_ecall_done = 1;
    in_ecall_ret  = 64'h2A;
    cyc();
    in_ecall_done = 0;
    #1;
    chk("wb_we", out_rf_we, 1);
    chk("wb_dest", out_rf_dest, 5'd10);
    chk("wb_data", out_rf_data, 64'h2A);
    cyc();
    chk("wb_we_off", out_rf_we, 0);
    chk("wb_data_off", out_rf_data, 0);

    // stall blocks FSM and enqueue, drain continues
    in_mem_ready = 0;
    store(64'h5000, 64'h5, 4'b0100);
    cyc();
    store(64'h5100, 64'h6, 4'b0100);
    in_stall     = 1;
    in_ecall_req = 1;
    in_mem_ready = 1;
    #1;
    chk("st_flush", out_flush, 0);
    chk("st_head", out_mem_addr, 64'h5000);
    cyc();
    in_wr_valid = 0; in_stall = 0; in_ecall_req = 0;
    #1;
    chk("st_empty", out_mem_valid, 0);
    chk("st_idle", out_stall, 0);

    // reset mid-drain discards stores
    in_mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      store(64'h6000 + 64'(i * 8), 64'(i), 4'b1000);
      cyc();
    end
    in_wr_valid  = 0;
    in_ecall_req = 1;
    cyc();
    in_ecall_req = 0;
    reset = 1;
    cyc();
    reset = 0;
    #1;
    chk("rd_valid", out_mem_valid, 0);
    chk("rd_stall", out_stall, 0);

    // reset while waiting for ecall completion
    in_ecall_req = 1;
    cyc();
    in_ecall_req = 0;
    cyc();
    cyc();
    chk("rw_wait_stall", out_stall, 1);
    reset = 1;
    cyc();
    reset = 0;
    in_ecall_done = 1;
    in_ecall_ret  = 64'h77;
    #1;
    chk("rw_stall", out_stall, 0);
    cyc();
    in_ecall_done = 0;
    #1;
    chk("rw_no_we", out_rf_we, 0);
    chk("rw_no_data", out_rf_data, 0);
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
